// File: rtl/io_input_conditioner.sv
// io_input_conditioner
//
// Conditions the raw board slide switches and push-buttons before they are
// mapped into the input words of the data memory. Each raw bit goes through a
// two-flop synchronizer and then a per-bit debouncer. All debouncers share one
// prescaler tick. A new level is accepted only after the synchronized input has
// differed from the debounced level for STABLE_TICKS consecutive ticks.
//
// Ports:
//   clock         : single clock; all state changes on its rising edge
//   reset         : asynchronous, active-low reset (0 = reset)
//   sw_raw        : asynchronous switch levels, 1 = up
//   key_raw_n     : asynchronous button levels, active-low (0 = pressed)
//   io_input_bus  : debounced {key_pressed, sw}, 1 = switch up / key pressed
//   key_press     : one-cycle pulse per key on each debounced press
//
// Parameters:
//   SW_COUNT, KEY_COUNT : number of switches / keys
//   IO_INPUT_BUS_LEN    : output width, must equal SW_COUNT + KEY_COUNT
//   TICK_DIV            : clock cycles per debounce tick (>= 1)
//   STABLE_TICKS        : mismatching ticks needed to accept a level (>= 1)

module io_input_conditioner #(
    parameter int SW_COUNT         = 10,
    parameter int KEY_COUNT        = 4,
    parameter int IO_INPUT_BUS_LEN = 14,
    parameter int TICK_DIV         = 50000,
    parameter int STABLE_TICKS     = 10
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [SW_COUNT-1:0]         sw_raw,
    input  logic [KEY_COUNT-1:0]        key_raw_n,
    output logic [IO_INPUT_BUS_LEN-1:0] io_input_bus,
    output logic [KEY_COUNT-1:0]        key_press
);

    localparam int N       = SW_COUNT + KEY_COUNT;
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W   = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(STABLE_TICKS - 1);

    // Keys are active-low on the board, so their synchronizer flops come out
    // of reset holding the "released" level (1).
    localparam logic [N-1:0] SYNC_RST = {{KEY_COUNT{1'b1}}, {SW_COUNT{1'b0}}};

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic [N-1:0] raw_in;
    logic [N-1:0] sync1_d, sync1_q;
    logic [N-1:0] sync2_d, sync2_q;
    logic [N-1:0] sync_lvl;

    assign raw_in = {key_raw_n, sw_raw};

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
    end

    // Key bits are inverted here so every bit downstream reads 1 = active.
    assign sync_lvl = {~sync2_q[N-1:SW_COUNT], sync2_q[SW_COUNT-1:0]};

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_d, presc_q;
    logic               tick;

    // With TICK_DIV = 1 the counter is stuck at 0 and tick is always high.
    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        if (tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debouncer
    // ------------------------------------------------------------------
    logic [N-1:0]            deb_d, deb_q;
    logic [N-1:0][CNT_W-1:0] cnt_d, cnt_q;

    // cnt counts ticks seen while the synchronized level disagrees with the
    // debounced level. Any agreement clears it, so a glitch that returns
    // before qualifying leaves no residue.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < N; i++) begin
            if (sync_lvl[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick && (cnt_q[i] == CNT_LAST)) begin
                deb_d[i] = sync_lvl[i];
                cnt_d[i] = '0;
            end else if (tick) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Press edge detector
    // ------------------------------------------------------------------
    logic [KEY_COUNT-1:0] prev_key_d, prev_key_q;

    always_comb begin
        prev_key_d = deb_q[N-1:SW_COUNT];
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q    <= SYNC_RST;
            sync2_q    <= SYNC_RST;
            presc_q    <= '0;
            deb_q      <= '0;
            cnt_q      <= '0;
            prev_key_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            presc_q    <= presc_d;
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            prev_key_q <= prev_key_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registered levels only, no path from the raw pins
    // ------------------------------------------------------------------
    assign io_input_bus = deb_q;
    assign key_press    = deb_q[N-1:SW_COUNT] & ~prev_key_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner with TICK_DIV = 4, STABLE_TICKS = 3.
// A reference model advances on every rising clock edge and pushes the
// expected {key_press, io_input_bus} into exp_q; a monitor on the falling
// edge pops and compares. Directed scenarios add latency and pulse checks.

module tb_io_input_conditioner;

    localparam int SW  = 10;
    localparam int KEY = 4;
    localparam int N   = SW + KEY;
    localparam int TD  = 4;
    localparam int ST  = 3;
    localparam int EW  = KEY + N;

    logic           clock;
    logic           reset;
    logic [SW-1:0]  sw_raw;
    logic [KEY-1:0] key_raw_n;
    logic [N-1:0]   io_input_bus;
    logic [KEY-1:0] key_press;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];

    io_input_conditioner #(
        .SW_COUNT        (SW),
        .KEY_COUNT       (KEY),
        .IO_INPUT_BUS_LEN(N),
        .TICK_DIV        (TD),
        .STABLE_TICKS    (ST)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sw_raw      (sw_raw),
        .key_raw_n   (key_raw_n),
        .io_input_bus(io_input_bus),
        .key_press   (key_press)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Input levels travel through a 2-deep delay line (normalised so 1 =
    // active); each bit counts ticks seen while continuously disagreeing
    // with its accepted level, and accepts on the ST-th such tick.
    int           m_seen[N];
    bit [N-1:0]   m_deb;
    bit [N-1:0]   m_hist[$];
    int           m_edges;

    function automatic void model_reset();
        m_deb = '0;
        foreach (m_seen[i]) m_seen[i] = 0;
        m_hist.delete();
        m_hist.push_back('0);
        m_hist.push_back('0);
        m_edges = 0;
    endfunction

    function automatic void model_edge(input logic [SW-1:0] sw, input logic [KEY-1:0] kn);
        bit [N-1:0]  lvl;
        bit [N-1:0]  old;
        bit          tk;
        logic [EW-1:0] e;
        old = m_deb;
        lvl = m_hist.pop_front();
        m_hist.push_back({~kn, sw});
        m_edges++;
        tk = (((m_edges - 1) % TD) == TD - 1);
        for (int i = 0; i < N; i++) begin
            if (lvl[i] == m_deb[i]) begin
                m_seen[i] = 0;
            end else if (tk) begin
                m_seen[i] = m_seen[i] + 1;
                if (m_seen[i] == ST) begin
                    m_deb[i]  = lvl[i];
                    m_seen[i] = 0;
                end
            end
        end
        e = {m_deb[N-1:SW] & ~old[N-1:SW], m_deb};
        exp_q.push_back(e);
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                model_reset();
                exp_q.delete();
            end else begin
                model_edge(sw_raw, key_raw_n);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                check("rst_bus", 32'(io_input_bus), 32'd0);
                check("rst_kp", 32'(key_press), 32'd0);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_bus", 32'(io_input_bus), 32'(e[N-1:0]));
                check("sb_kp", 32'(key_press), 32'(e[EW-1:N]));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int nz, lat, found, seen, pulses, pulse_cyc, rise_cyc, drops;
        int ticks, last_tick, bad_int, kp_cycles;
        logic [KEY-1:0] pulse_val, kp_seen_val;
        logic [KEY-1:0] key_at_kp;
        logic [SW-1:0]  prev_sw;
        int hold;

        // ---- 1: reset values ----
        reset     = 1'b1;
        sw_raw    = '0;
        key_raw_n = '1;
        #1 reset  = 1'b0;
        #1;
        check("s1_bus_async", 32'(io_input_bus), 32'd0);
        check("s1_kp_async", 32'(key_press), 32'd0);
        repeat (3) step();
        reset = 1'b1;
        nz = 0;
        repeat (50) begin
            step();
            if (io_input_bus != '0 || key_press != '0) nz++;
        end
        check("s1_quiet", 32'(nz), 32'd0);

        // ---- 2: single switch rise ----
        sw_raw[3] = 1'b1;
        found = 0;
        lat   = 0;
        for (int k = 1; k <= 40 && found == 0; k++) begin
            step();
            if (io_input_bus[3]) begin
                found = 1;
                lat   = k;
            end
        end
        check("s2_found", 32'(found), 32'd1);
        check("s2_lat_window", 32'((lat >= 11) && (lat <= 14)), 32'd1);
        check("s2_others", 32'(io_input_bus & ~14'h0008), 32'd0);
        drops = 0;
        repeat (10) begin
            step();
            if (!io_input_bus[3]) drops++;
        end
        check("s2_hold", 32'(drops), 32'd0);
        sw_raw[3] = 1'b0;
        repeat (20) step();

        // ---- 3: glitch rejection ----
        seen = 0;
        sw_raw[0] = 1'b1;
        repeat (6) begin
            step();
            if (io_input_bus[0]) seen++;
        end
        sw_raw[0] = 1'b0;
        repeat (20) begin
            step();
            if (io_input_bus[0]) seen++;
        end
        check("s3_no_pass", 32'(seen), 32'd0);
        check("s3_cnt0_zero", 32'(dut.cnt_q[0]), 32'd0);

        // ---- 4: key press and release ----
        key_raw_n[2] = 1'b0;
        pulses = 0; pulse_cyc = -1; rise_cyc = -1; pulse_val = '0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (io_input_bus[12] && rise_cyc < 0) rise_cyc = k;
            if (key_press != '0) begin
                pulses++;
                pulse_cyc = k;
                pulse_val = key_press;
            end
        end
        check("s4_pressed", 32'(io_input_bus[12]), 32'd1);
        check("s4_pulse_count", 32'(pulses), 32'd1);
        check("s4_pulse_val", 32'(pulse_val), 32'h4);
        check("s4_pulse_at_rise", 32'(pulse_cyc == rise_cyc), 32'd1);
        key_raw_n[2] = 1'b1;
        found = 0; nz = 0;
        for (int k = 1; k <= 14 && found == 0; k++) begin
            step();
            if (key_press != '0) nz++;
            if (!io_input_bus[12]) found = 1;
        end
        check("s4_released", 32'(found), 32'd1);
        check("s4_no_release_pulse", 32'(nz), 32'd0);
        repeat (5) step();

        // ---- random phase ----
        for (int r = 0; r < 50; r++) begin
            sw_raw    = sw_raw ^ SW'($urandom & $urandom);
            key_raw_n = key_raw_n ^ KEY'($urandom & $urandom);
            hold = $urandom_range(1, 24);
            repeat (hold) step();
        end
        #2 reset = 1'b0;
        #1;
        check("rand_async_bus", 32'(io_input_bus), 32'd0);
        check("rand_async_kp", 32'(key_press), 32'd0);
        step();
        reset     = 1'b1;
        sw_raw    = '0;
        key_raw_n = '1;
        repeat (20) step();

        // ---- 5: async reset mid-debounce ----
        sw_raw = 10'h3FF;
        repeat (8) step();
        #2 reset = 1'b0;
        #1;
        check("s5_bus_async", 32'(io_input_bus), 32'd0);
        check("s5_cnt_cleared", 32'(dut.cnt_q[9]), 32'd0);
        repeat (2) step();
        reset = 1'b1;
        found = 0; lat = 0;
        for (int k = 1; k <= 30 && found == 0; k++) begin
            prev_sw = io_input_bus[SW-1:0];
            step();
            if (io_input_bus[SW-1:0] != prev_sw) begin
                found = 1;
                lat   = k;
                check("s5_same_cycle", 32'(io_input_bus[SW-1:0]), 32'h3FF);
                check("s5_prev_zero", 32'(prev_sw), 32'd0);
            end
        end
        check("s5_found", 32'(found), 32'd1);
        check("s5_lat_window", 32'((lat >= 11) && (lat <= 14)), 32'd1);

        // ---- 6: simultaneous keys and prescaler wrap ----
        key_raw_n = 4'b0000;
        ticks = 0; last_tick = -1; bad_int = 0; kp_cycles = 0;
        kp_seen_val = '0; key_at_kp = '0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (dut.tick) begin
                if (last_tick >= 0 && (k - last_tick) != TD) bad_int++;
                last_tick = k;
                ticks++;
            end
            if (key_press != '0) begin
                kp_cycles++;
                kp_seen_val = key_press;
                key_at_kp   = io_input_bus[N-1:SW];
            end
        end
        check("s6_tick_count", 32'(ticks >= 14), 32'd1);
        check("s6_tick_spacing", 32'(bad_int), 32'd0);
        check("s6_kp_cycles", 32'(kp_cycles), 32'd1);
        check("s6_kp_val", 32'(kp_seen_val), 32'hF);
        check("s6_keys_at_kp", 32'(key_at_kp), 32'hF);
        check("s6_keys_final", 32'(io_input_bus[N-1:SW]), 32'hF);

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

Conditions the raw board switches and push-buttons before they enter the memory-mapped input words of the data memory. Every input bit passes through a two-flop synchronizer and a per-bit debouncer that runs off a shared prescaler tick. The block drives the 14-bit input bus directly, laid out as {KEY, SW}. It also emits one-cycle key-press pulses for later interrupt or edge-capture use.

## Interface
- `SW_COUNT`, 10, number of slide switches; bus bits [SW_COUNT-1:0].
- `KEY_COUNT`, 4, number of push-buttons; bus bits [SW_COUNT+KEY_COUNT-1:SW_COUNT].
- `IO_INPUT_BUS_LEN`, 14, output bus width; must equal SW_COUNT+KEY_COUNT.
- `TICK_DIV`, 50000, clock cycles per debounce tick (1 ms at 50 MHz); must be ≥1.
- `STABLE_TICKS`, 10, consecutive mismatching ticks needed to accept a new level; must be ≥1.

Ports:
- `clock` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset; 0 = reset.
- `sw_raw` input SW_COUNT: asynchronous switch levels, 1 = up.
- `key_raw_n` input KEY_COUNT: asynchronous button levels, active-low (0 = pressed).
- `io_input_bus` output IO_INPUT_BUS_LEN: debounced {key_pressed, sw}; 1 = switch up or key pressed.
- `key_press` output KEY_COUNT: one-cycle pulse per key on each debounced press.

## Operation
- **Synchronizer.** Two flops per bit.
  - SW flops reset to 0; KEY flops reset to 1, meaning released.
  - KEY is inverted after the second flop, so sync_key = 1 means pressed.
- **Prescaler.** Counter of width clog2(TICK_DIV), reset to 0, counting 0..TICK_DIV-1.
  - `tick` = 1 for exactly the cycle in which the count equals TICK_DIV-1; the counter then wraps to 0.
  - With TICK_DIV=1, tick is 1 every cycle.
- **Debouncer, per bit i.** State is the debounced level deb[i] (reset 0) and a counter cnt[i] (reset 0, wide enough for STABLE_TICKS-1). Each cycle:
  - If sync[i] == deb[i]: cnt[i] ← 0. This covers glitches that return before qualification.
  - Else if tick and cnt[i] == STABLE_TICKS-1: deb[i] ← sync[i] and cnt[i] ← 0.
  - Else if tick: cnt[i] ← cnt[i]+1.
  - Otherwise cnt[i] holds.
- **Output bus.** io_input_bus = {deb_key, deb_sw}, driven straight from the deb registers with no combinational path from the raw inputs.
- **Press pulse.** prev_key register (reset 0) samples deb_key every cycle.
  - key_press = deb_key & ~prev_key.
  - The pulse is high in the first cycle io_input_bus shows the key as pressed, for exactly one cycle.
  - Release produces no pulse.
- **Independence.** All bits are independent, so any number may qualify in the same cycle.

## Timing
- **Reset values.** While reset = 0, asynchronously and without a clock edge:
  - io_input_bus = 0 and key_press = 0.
  - All counters are 0.
  - deb = 0, prev_key = 0.
- **Reset release.** Behaviour resumes on the first rising edge with reset = 1. The prescaler restarts from 0.
- **Latency.** After a raw level change that is held stable:
  - The sync output changes 2 edges after the first sampling edge.
  - deb changes on the edge of the STABLE_TICKS-th tick at which the mismatch is present.
  - Total: 2 + (STABLE_TICKS-1)·TICK_DIV + 1 edges at minimum, and 2 + STABLE_TICKS·TICK_DIV edges at maximum.
- **Rejection.** A raw pulse shorter than (STABLE_TICKS-1)·TICK_DIV cycles never reaches io_input_bus.
- **Reset mid-debounce.** All partial counts are discarded. After release, a held input re-qualifies with the full latency.
- **Reset while a key is held.** If a key is held through reset release, it qualifies normally and produces one key_press pulse.

## Test plan
All scenarios use TICK_DIV=4, STABLE_TICKS=3.
1. **Reset values.** reset=0, key_raw_n=4'hF, sw_raw=0, no clock → io_input_bus=14'h0000 and key_press=0. Release reset → both stay 0 for 50 cycles.
2. **Single switch rise.** sw_raw[3] 0→1 and held → io_input_bus[3] rises no earlier than 11 and no later than 14 edges after the first sampling edge, then stays 1. All other bits stay 0.
3. **Glitch rejection.** sw_raw[0] high for 6 cycles then low → io_input_bus[0] stays 0 throughout. Internal cnt[0] returns to 0.
4. **Key press and release.** key_raw_n[2] driven 0 for 30 cycles, then 1:
   - Press: io_input_bus[12]=1, with key_press=4'b0100 for exactly one cycle coincident with that rise.
   - Release: io_input_bus[12] returns to 0 within 14 edges and key_press stays 0.
5. **Async reset mid-debounce.** sw_raw=10'h3FF held 8 cycles, then reset=0 between clock edges → io_input_bus=0 immediately. After release with sw_raw still 10'h3FF → io_input_bus[9:0]=10'h3FF, all ten bits rising in the same cycle, 11–14 edges after release.
6. **Simultaneous keys and prescaler wrap.** key_raw_n=4'b0000 held, and tick is observed every 4th cycle across ≥10 wraps → io_input_bus[13:10]=4'hF and key_press=4'hF in a single cycle.
